adc_sample_scheduler: RTL
=========================

ADC_SAMPLE_SCHEDULER -- requirements
Module: adc_sample_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, result FIFO depth in words (power of 2, 2..64).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles per wait state before abort.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port run  in  1  level; high enables scheduled sampling.
REQ-006 SHALL have port period  in  16  start-to-start interval in clk cycles.
REQ-007 SHALL have port burst_len  in  8  samples per run; 0 = continuous.
REQ-008 SHALL have port adc_start  out  1  one-cycle pulse to the driver's en.
REQ-009 SHALL have port adc_idle  in  1  driver idle flag; low while converting.
REQ-010 SHALL have port adc_data  in  16  driver result word.
REQ-011 SHALL have ports rd_en in 1, rd_data out 16, fifo_empty out 1, fifo_full out 1: FWFT read side.
REQ-012 SHALL have ports overflow out 1, timeout_err out 1 (sticky) and clr_err in 1.
REQ-013 SHALL have port busy  out  1  high whenever FSM is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE, STORE, HOLD.
REQ-015 IDLE->START when run=1; clears sample counter and period counter.
REQ-016 START SHALL assert adc_start for exactly one cycle, load period counter with period-1, go to WAIT_BUSY.
REQ-017 WAIT_BUSY->WAIT_DONE on adc_idle=0; WAIT_DONE->STORE on adc_idle=1.
REQ-018 Either wait state lasting TIMEOUT cycles SHALL set timeout_err and go to IDLE without storing.
REQ-019 STORE SHALL write adc_data (or the average, REQ-030) to the FIFO in one cycle and increment the 8-bit sample counter.
REQ-020 STORE->IDLE when burst_len!=0 and counter==burst_len; else ->HOLD.
REQ-021 HOLD->START when the period counter reaches 0; the counter decrements every cycle from START onward, saturating at 0.
REQ-022 period shorter than conversion time: next START SHALL occur the cycle after HOLD is entered.
REQ-023 period and burst_len SHALL be sampled in IDLE and START only; changes mid-sample take effect at the next START.
REQ-024 run=0 SHALL not abort a conversion in flight; FSM returns to IDLE at the next HOLD or STORE exit.
REQ-025 FIFO full at STORE: word SHALL be dropped, overflow set, sequencing continues.
REQ-026 rd_en on empty FIFO SHALL be ignored; simultaneous write and read on full FIFO SHALL succeed (no overflow).
REQ-027 rd_data SHALL show the oldest word whenever fifo_empty=0; rd_en pops it.
REQ-028 clr_err SHALL clear overflow and timeout_err the following cycle; a same-cycle set event wins.

Reset
REQ-029 rst low SHALL immediately force IDLE, adc_start=0, busy=0, FIFO empty (fifo_empty=1, fifo_full=0), rd_data=0, overflow=0, timeout_err=0, all counters 0; reset mid-conversion discards the sample.

Configuration
REQ-030 ADC_SCHED_AVG_EN defined: each stored word SHALL be the mean of 4 consecutive conversions (18-bit sum, >>2, truncating); burst_len counts stored words; a timeout discards the partial sum.
REQ-031 ADC_SCHED_AVG_EN undefined: every conversion SHALL be stored raw; no accumulator logic present.

Verification
REQ-032 run=1, period=200, burst_len=3, model driver busy 100 cycles returning 0x1234, 0x5678, 0x9ABC -> adc_start pulses 200 cycles apart, FIFO holds 3 words in order, busy drops after third STORE.
REQ-033 period=10, burst_len=2, 100-cycle conversion -> second adc_start one cycle after HOLD entry, no overlap.
REQ-034 Continuous mode, no reads, FIFO_DEPTH=8 -> fifo_full after 8 samples, 9th sets overflow, clr_err clears it.
REQ-035 Driver never drops adc_idle -> timeout_err set 255 cycles after adc_start, FSM IDLE, FIFO unchanged.
REQ-036 rst low 50 cycles into a conversion -> all outputs at reset values; after release with run=1 a fresh adc_start issues.
REQ-037 With ADC_SCHED_AVG_EN, conversions 0x0004, 0x0008, 0x000C, 0x0011 -> single stored word 0x000A.

Source files
------------

// File: rtl/adc_sample_scheduler.sv
// ADC sample scheduler: paced adc_start pulses, driver handshake with per-state timeout,
// FWFT result FIFO. Define ADC_SCHED_AVG_EN to store the mean of every 4 conversions.
module adc_sample_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] period,
  input  logic [7:0]  burst_len,
  output logic        adc_start,
  input  logic        adc_idle,
  input  logic [15:0] adc_data,
  input  logic        rd_en,
  output logic [15:0] rd_data,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        overflow,
  output logic        timeout_err,
  input  logic        clr_err,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WAIT_ONE = TW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, STORE, HOLD} state_t;
  typedef struct packed {
    logic        vld;
    logic [15:0] data;
  } wr_req_t;

  state_t        state, next;
  logic [15:0]   period_cnt;
  logic [7:0]    sample_cnt, cfg_burst;
  logic [TW-1:0] wait_cnt;
  logic          to_evt, burst_done;
  wr_req_t       word;
  logic          pop, push, ovf_evt;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [15:0]   mem [FIFO_DEPTH];

  assign burst_done = word.vld && (cfg_burst != 8'd0) && ((sample_cnt + 8'd1) == cfg_burst);

  always_comb begin
    next   = state;
    to_evt = 1'b0;
    case (state)
      IDLE:      if (run) next = START;
      START:     next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!adc_idle) next = WAIT_DONE;
        else if (wait_cnt == TO_LAST) begin
          next   = IDLE;
          to_evt = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (adc_idle) next = STORE;
        else if (wait_cnt == TO_LAST) begin
          next   = IDLE;
          to_evt = 1'b1;
        end
      end
      STORE:     next = (burst_done || !run) ? IDLE : HOLD;
      // Leave one cycle early so START lands exactly period cycles after the previous one.
      HOLD: begin
        if (!run) next = IDLE;
        else if (period_cnt <= 16'd1) next = START;
      end
      default:   next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      period_cnt <= '0;
      sample_cnt <= '0;
      cfg_burst  <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= next;
      if ((state == WAIT_BUSY || state == WAIT_DONE) && next == state) wait_cnt <= wait_cnt + WAIT_ONE;
      else wait_cnt <= '0;
      case (state)
        IDLE: begin
          period_cnt <= '0;
          sample_cnt <= '0;
          cfg_burst  <= burst_len;
        end
        START: begin
          period_cnt <= (period == 16'd0) ? 16'd0 : period - 16'd1;
          cfg_burst  <= burst_len;
        end
        default: if (period_cnt != 16'd0) period_cnt <= period_cnt - 16'd1;
      endcase
      if (word.vld) sample_cnt <= sample_cnt + 8'd1;
    end
  end

`ifdef ADC_SCHED_AVG_EN
  logic [17:0] acc, acc_sum;
  logic [1:0]  avg_cnt;

  assign acc_sum = acc + {2'b00, adc_data};
  assign word    = {(state == STORE) && (avg_cnt == 2'd3), acc_sum[17:2]};

  // Partial sums never survive a trip through IDLE or a timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      avg_cnt <= '0;
    end else if (state == IDLE || to_evt || word.vld) begin
      acc     <= '0;
      avg_cnt <= '0;
    end else if (state == STORE) begin
      acc     <= acc_sum;
      avg_cnt <= avg_cnt + 2'd1;
    end
  end
`else
  assign word = {state == STORE, adc_data};
`endif

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = rd_en && !fifo_empty;
  assign push       = word.vld && (!fifo_full || pop);
  assign ovf_evt    = word.vld && fifo_full && !pop;
  assign rd_data    = fifo_empty ? 16'd0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word.data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (ovf_evt) overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (to_evt) timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

  assign adc_start = (state == START);
  assign busy      = (state != IDLE);

endmodule
